// File: rtl/multiplicador_controle_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
// Provides the FSM state enum, widths and a carry-chain counter helper.
package mult_pkg;

    localparam int MULT_WIDTH  = 16;
    localparam int MULT_CONT_W = 5;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Explicit half-adder chain: the block's only arithmetic adder is the Adder instance.
    function automatic logic [MULT_CONT_W-1:0] incr_cont(input logic [MULT_CONT_W-1:0] valor);
        logic [MULT_CONT_W-1:0] resultado;
        logic                   carry;
        carry = 1'b1;
        for (int i = 0; i < MULT_CONT_W; i++) begin
            resultado[i] = valor[i] ^ carry;
            carry        = carry & valor[i];
        end
        return resultado;
    endfunction

endpackage

// File: rtl/multiplicador_controle_adder.sv
// Adder: unsigned WIDTH-bit adder with carry-out in Soma[WIDTH].
module Adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] OperandoA,
    input  logic [WIDTH-1:0] OperandoB,
    output logic [WIDTH:0]   Soma
);

    assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule

// File: rtl/multiplicador_controle.sv
// Sequential shift-add multiplier controller driving one Adder instance.
// Optional build macro MULT_EARLY_EXIT_EN finishes early once the multiplier runs out of set bits.
module multiplicador_controle
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     OperandoA,
    input  logic [WIDTH-1:0]     OperandoB,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Pronto,
    output logic                 Ocupado
);

    estado_t                estado_r;
    logic [WIDTH-1:0]       acc_r;
    logic [WIDTH-1:0]       baixo_r;
    logic [WIDTH-1:0]       m_r;
    logic [WIDTH-1:0]       mcand_r;
    logic [MULT_CONT_W-1:0] cont_r;
    logic [2*WIDTH-1:0]     produto_r;
    logic                   pronto_r;
    logic                   ocupado_r;

    logic [WIDTH-1:0]       adder_b_s;
    logic [WIDTH:0]         soma_s;
    logic [WIDTH-1:0]       acc_next_s;
    logic [WIDTH-1:0]       baixo_next_s;
    logic [MULT_CONT_W-1:0] cont_next_s;

    Adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .OperandoA (acc_r),
        .OperandoB (adder_b_s),
        .Soma      (soma_s)
    );

    // Partial-product selection and one shift-add iteration.
    always_comb begin
        if (m_r[0]) begin
            adder_b_s = mcand_r;
        end else begin
            adder_b_s = {WIDTH{1'b0}};
        end
        acc_next_s   = soma_s[WIDTH:1];
        baixo_next_s = {soma_s[0], baixo_r[WIDTH-1:1]};
        cont_next_s  = incr_cont(cont_r);
    end

`ifdef MULT_EARLY_EXIT_EN
    logic [3*WIDTH-1:0] ext_s;
    logic [2*WIDTH-1:0] atalho_s;

    // Remaining right shift by (16 - Cont), done as a left shift by Cont then dropping 16 bits.
    always_comb begin
        ext_s    = {{WIDTH{1'b0}}, acc_r, baixo_r} << cont_r;
        atalho_s = ext_s[3*WIDTH-1:WIDTH];
    end
`endif

    // Controller FSM with registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_r  <= OCIOSO;
            acc_r     <= {WIDTH{1'b0}};
            baixo_r   <= {WIDTH{1'b0}};
            m_r       <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            cont_r    <= {MULT_CONT_W{1'b0}};
            produto_r <= {(2*WIDTH){1'b0}};
            pronto_r  <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    pronto_r <= 1'b0;
                    if (Start) begin
                        mcand_r   <= OperandoA;
                        m_r       <= OperandoB;
                        acc_r     <= {WIDTH{1'b0}};
                        baixo_r   <= {WIDTH{1'b0}};
                        cont_r    <= {MULT_CONT_W{1'b0}};
                        ocupado_r <= 1'b1;
                        estado_r  <= CALCULA;
                    end else begin
                        ocupado_r <= 1'b0;
                        estado_r  <= OCIOSO;
                    end
                end
                CALCULA: begin
                    ocupado_r <= 1'b1;
`ifdef MULT_EARLY_EXIT_EN
                    if (m_r == {WIDTH{1'b0}}) begin
                        {acc_r, baixo_r} <= atalho_s;
                        produto_r        <= atalho_s;
                        pronto_r         <= 1'b1;
                        estado_r         <= FIM;
                    end else begin
`else
                    begin
`endif
                        acc_r   <= acc_next_s;
                        baixo_r <= baixo_next_s;
                        m_r     <= {1'b0, m_r[WIDTH-1:1]};
                        cont_r  <= cont_next_s;
                        if (cont_r == MULT_CONT_W'(15)) begin
                            produto_r <= {acc_next_s, baixo_next_s};
                            pronto_r  <= 1'b1;
                            estado_r  <= FIM;
                        end else begin
                            pronto_r  <= 1'b0;
                            estado_r  <= CALCULA;
                        end
                    end
                end
                FIM: begin
                    pronto_r  <= 1'b0;
                    ocupado_r <= 1'b0;
                    estado_r  <= OCIOSO;
                end
                default: begin
                    pronto_r  <= 1'b0;
                    ocupado_r <= 1'b0;
                    estado_r  <= OCIOSO;
                end
            endcase
        end
    end

    assign Produto = produto_r;
    assign Pronto  = pronto_r;
    assign Ocupado = ocupado_r;

endmodule

// File: tb/tb_multiplicador_controle.sv
// Self-checking bench for multiplicador_controle: vector table, corner sequences, operand sweep.
module tb_multiplicador_controle;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [15:0] OperandoA;
    logic [15:0] OperandoB;
    logic [31:0] Produto;
    logic        Pronto;
    logic        Ocupado;

    multiplicador_controle #(.WIDTH(16)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .OperandoA (OperandoA),
        .OperandoB (OperandoB),
        .Produto   (Produto),
        .Pronto    (Pronto),
        .Ocupado   (Ocupado)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
    } vec_t;

    typedef struct {
        logic [31:0] prod;
        int          accept;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pronto_cnt = 0;
    int   exp_pronto = 0;
    logic prev_pronto = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [15:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 16; i++) if (b[i]) msb = i;
        if (msb + 2 > 16) return 16;
        return msb + 2;
`else
        return 16;
`endif
    endfunction

    // Output monitor: pops the scoreboard on each Pronto.
    always @(negedge Clk) begin
        if (Pronto) begin
            exp_t e;
            pronto_cnt++;
            checks++;
            if (prev_pronto) begin
                errors++;
                $display("FAIL pronto_width: Pronto high two cycles in a row at cyc %0d", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pronto: Produto %h at cyc %0d, none expected", Produto, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (Produto !== e.prod) begin
                    errors++;
                    $display("FAIL produto: got %h expected %h", Produto, e.prod);
                end
                checks++;
                if (cyc != e.accept + e.lat) begin
                    errors++;
                    $display("FAIL latency: Pronto at cyc %0d expected %0d", cyc, e.accept + e.lat);
                end
            end
        end
        prev_pronto = Pronto;
    end

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [31:0] ax;
        logic [31:0] bx;
        ax = {16'd0, a};
        bx = {16'd0, b};
        e.prod   = ax * bx;
        e.accept = cyc + 1;
        e.lat    = lat_of(b);
        sb.push_back(e);
        exp_pronto++;
    endtask

    task automatic wait_pronto();
        int n;
        n = 0;
        while (pronto_cnt < exp_pronto && n < 60) begin
            @(negedge Clk);
            #1;
            n++;
        end
        checks++;
        if (pronto_cnt < exp_pronto) begin
            errors++;
            $display("FAIL timeout: pronto count %0d expected %0d", pronto_cnt, exp_pronto);
            pronto_cnt = exp_pronto;
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic do_mult(input logic [15:0] a, input logic [15:0] b);
        repeat (2) @(negedge Clk);
        OperandoA = a;
        OperandoB = b;
        Start     = 1'b1;
        push_exp(a, b);
        @(negedge Clk);
        Start = 1'b0;
        #1;
        check_val("ocupado_busy", {31'd0, Ocupado}, 32'd1);
        wait_pronto();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'd3,     16'd5,     32'd15};
        vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001};
        vecs[2] = '{16'h1234,  16'h0000,  32'h00000000};
        vecs[3] = '{16'h00FF,  16'h0101,  32'h0000FFFF};
        vecs[4] = '{16'hFFFF,  16'h0001,  32'h0000FFFF};
        vecs[5] = '{16'h8000,  16'h8000,  32'h40000000};
        vecs[6] = '{16'h0001,  16'h8000,  32'h00008000};
        vecs[7] = '{16'h0000,  16'hBEEF,  32'h00000000};

        Reset_n   = 1'b0;
        Start     = 1'b0;
        OperandoA = 16'd0;
        OperandoB = 16'd0;
        repeat (3) @(negedge Clk);
        #1;
        check_val("reset_produto", Produto, 32'd0);
        check_val("reset_pronto", {31'd0, Pronto}, 32'd0);
        check_val("reset_ocupado", {31'd0, Ocupado}, 32'd0);
        Reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_mult(vecs[i].a, vecs[i].b);
            check_val("table_produto", Produto, vecs[i].prod);
        end

        // Start raised mid-CALCULA must be ignored.
        repeat (2) @(negedge Clk);
        OperandoA = 16'd7;
        OperandoB = 16'd9;
        Start     = 1'b1;
        push_exp(16'd7, 16'd9);
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        OperandoA = 16'd2;
        OperandoB = 16'd2;
        Start     = 1'b1;
        repeat (4) @(negedge Clk);
        Start = 1'b0;
        wait_pronto();
        repeat (10) @(negedge Clk);
        #1;
        check_val("ignored_start_held", Produto, 32'd63);
        check_val("ignored_start_count", pronto_cnt, exp_pronto);

        // Reset in the middle of CALCULA abandons the operation.
        repeat (2) @(negedge Clk);
        OperandoA = 16'h1234;
        OperandoB = 16'h5678;
        Start     = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (8) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("midreset_produto", Produto, 32'd0);
        check_val("midreset_pronto", {31'd0, Pronto}, 32'd0);
        check_val("midreset_ocupado", {31'd0, Ocupado}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (25) @(negedge Clk);
        #1;
        check_val("midreset_no_pronto", pronto_cnt, exp_pronto);
        do_mult(16'h8000, 16'd2);
        check_val("after_reset_produto", Produto, 32'h00010000);

        // Sweep with Start held high: a new acceptance every 18 cycles.
        repeat (3) @(negedge Clk);
        Start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                OperandoA = 16'(i);
                OperandoB = 16'(j);
`ifdef MULT_EARLY_EXIT_EN
                push_exp(16'(i), 16'(j));
                @(negedge Clk);
                while (Ocupado) @(negedge Clk);
`else
                push_exp(16'(i), 16'(j));
                repeat (18) @(negedge Clk);
`endif
            end
        end
        Start = 1'b0;
        wait_pronto();
        repeat (5) @(negedge Clk);
        check_val("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
